// File: rtl/stage3_execute_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: decode-side operands and controls in, EX/MEM register and flags out.
interface stage3_execute_if #(
    parameter int WORD_LENGTH = 8,
    parameter int RADDR       = 3
);
    logic                    stall;
    logic                    flush;
    logic                    in_valid;
    logic [WORD_LENGTH-1:0]  readData1;
    logic [WORD_LENGTH-1:0]  readData2;
    logic [RADDR-1:0]        rs1;
    logic [RADDR-1:0]        rs2;
    logic [WORD_LENGTH-1:0]  const_disp;
    logic [2:0]              shiftCount;
    logic                    AluInputBSel;
    logic [3:0]              ALUfunction;
    logic                    Cenb;
    logic                    Zenb;
    logic [RADDR-1:0]        dest;
    logic                    regWrite_in;
    logic                    DMMemWrite_in;
    logic                    LDM_in;
    logic                    wdSel_in;
    logic                    wb_regWrite;
    logic [RADDR-1:0]        wb_writeAddress;
    logic [WORD_LENGTH-1:0]  wb_data;

    logic                    C;
    logic                    Z;
    logic [WORD_LENGTH-1:0]  aluResult;
    logic [WORD_LENGTH-1:0]  storeData;
    logic [RADDR-1:0]        dest_out;
    logic                    regWrite_out;
    logic                    DMMemWrite_out;
    logic                    LDM_out;
    logic                    wdSel_out;
    logic                    valid_out;

    modport master (
        output stall, flush, in_valid, readData1, readData2, rs1, rs2, const_disp,
               shiftCount, AluInputBSel, ALUfunction, Cenb, Zenb, dest,
               regWrite_in, DMMemWrite_in, LDM_in, wdSel_in,
               wb_regWrite, wb_writeAddress, wb_data,
        input  C, Z, aluResult, storeData, dest_out,
               regWrite_out, DMMemWrite_out, LDM_out, wdSel_out, valid_out
    );

    modport slave (
        input  stall, flush, in_valid, readData1, readData2, rs1, rs2, const_disp,
               shiftCount, AluInputBSel, ALUfunction, Cenb, Zenb, dest,
               regWrite_in, DMMemWrite_in, LDM_in, wdSel_in,
               wb_regWrite, wb_writeAddress, wb_data,
        output C, Z, aluResult, storeData, dest_out,
               regWrite_out, DMMemWrite_out, LDM_out, wdSel_out, valid_out
    );
endinterface

// File: rtl/stage3_execute.sv
// Execute stage: operand forwarding, ALU/shift, C/Z flags and the EX/MEM register; 1-cycle latency.
// stall holds every register and flag; flush or an empty slot writes a bubble and leaves the flags alone.
module stage3_execute #(
    parameter int WORD_LENGTH = 8,
    parameter int RADDR       = 3
) (
    input  logic              clk,
    input  logic              rst,
    stage3_execute_if.slave   bus
);
    localparam int W = WORD_LENGTH;

    logic [W-1:0]   opA;
    logic [W-1:0]   fwdB;
    logic [W-1:0]   opB;
    logic [W-1:0]   result;
    logic           co;
    logic           exFwdOk;
    logic [W:0]     sum;
    logic [2*W-1:0] wide;

    // Loads are not forwarded from EX/MEM: their data only exists after the memory stage.
    assign exFwdOk = bus.valid_out & bus.regWrite_out & ~bus.LDM_out;

    always_comb begin
        opA = bus.readData1;
        if (exFwdOk && bus.dest_out == bus.rs1)
            opA = bus.aluResult;
        else if (bus.wb_regWrite && bus.wb_writeAddress == bus.rs1)
            opA = bus.wb_data;

        fwdB = bus.readData2;
        if (exFwdOk && bus.dest_out == bus.rs2)
            fwdB = bus.aluResult;
        else if (bus.wb_regWrite && bus.wb_writeAddress == bus.rs2)
            fwdB = bus.wb_data;

        opB = bus.AluInputBSel ? bus.const_disp : fwdB;
    end

    always_comb begin
        result = opA;
        co     = bus.C;
        sum    = '0;
        wide   = '0;
        case (bus.ALUfunction)
            4'h0: begin sum = {1'b0, opA} + {1'b0, opB};                   result = sum[W-1:0]; co = sum[W]; end
            4'h1: begin sum = {1'b0, opA} + {1'b0, opB} + {{W{1'b0}}, bus.C}; result = sum[W-1:0]; co = sum[W]; end
            4'h2: begin sum = {1'b0, opA} - {1'b0, opB};                   result = sum[W-1:0]; co = sum[W]; end
            4'h3: begin sum = {1'b0, opA} - {1'b0, opB} - {{W{1'b0}}, bus.C}; result = sum[W-1:0]; co = sum[W]; end
            4'h4: result = opA & opB;
            4'h5: result = opA | opB;
            4'h6: result = opA ^ opB;
            4'h7: result = opA & ~opB;
            4'h8: begin
                if (bus.shiftCount != 3'd0) begin
                    wide   = {{W{1'b0}}, opA} << bus.shiftCount;
                    result = wide[W-1:0];
                    co     = wide[W];
                end
            end
            4'h9: begin
                if (bus.shiftCount != 3'd0) begin
                    wide   = {opA, {W{1'b0}}} >> bus.shiftCount;
                    result = wide[2*W-1:W];
                    co     = wide[W-1];
                end
            end
            4'hA: begin wide = {opA, opA} << bus.shiftCount; result = wide[2*W-1:W]; end
            4'hB: begin wide = {opA, opA} >> bus.shiftCount; result = wide[W-1:0];   end
            4'hC: result = opB;
            default: result = opA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.C              <= 1'b0;
            bus.Z              <= 1'b0;
            bus.aluResult      <= '0;
            bus.storeData      <= '0;
            bus.dest_out       <= '0;
            bus.regWrite_out   <= 1'b0;
            bus.DMMemWrite_out <= 1'b0;
            bus.LDM_out        <= 1'b0;
            bus.wdSel_out      <= 1'b0;
            bus.valid_out      <= 1'b0;
        end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            bus.regWrite_out   <= 1'b0;
            bus.DMMemWrite_out <= 1'b0;
            bus.LDM_out        <= 1'b0;
            bus.valid_out      <= 1'b0;
        end else if (!bus.stall) begin
            bus.aluResult      <= result;
            bus.storeData      <= fwdB;
            bus.dest_out       <= bus.dest;
            bus.regWrite_out   <= bus.regWrite_in;
            bus.DMMemWrite_out <= bus.DMMemWrite_in;
            bus.LDM_out        <= bus.LDM_in;
            bus.wdSel_out      <= bus.wdSel_in;
            bus.valid_out      <= 1'b1;
            if (bus.Cenb) bus.C <= co;
            if (bus.Zenb) bus.Z <= (result == '0);
        end
    end
endmodule

// File: tb/tb_stage3_execute.sv
module tb_stage3_execute;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stage3_execute_if bus ();
    stage3_execute dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Reference model of the architectural state after each edge.
    bit       mC, mZ, mValid, mRw, mMw, mLdm, mWd, mKnown;
    int       mAlu, mStore, mDest;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic void refAlu(input int f, input int a, input int b, input int n,
                                   input int cin, output int r, output int co);
        co = cin;
        r  = a;
        case (f)
            0:  begin r = (a + b) % 256;        co = (a + b) / 256; end
            1:  begin r = (a + b + cin) % 256;  co = (a + b + cin) / 256; end
            2:  begin r = (a - b + 256) % 256;  co = (a < b) ? 1 : 0; end
            3:  begin r = (a - b - cin + 512) % 256; co = (a < b + cin) ? 1 : 0; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = a & (255 - b);
            8:  if (n != 0) begin r = (a * (1 << n)) % 256; co = (a / (1 << (8 - n))) % 2; end
            9:  if (n != 0) begin r = a / (1 << n);         co = (a / (1 << (n - 1))) % 2; end
            10: r = ((a * (1 << n)) + (a / (1 << (8 - n)))) % 256;
            11: r = ((a / (1 << n)) + (a * (1 << (8 - n)))) % 256;
            12: r = b;
            default: r = a;
        endcase
    endfunction

    function automatic int pick(input int rs, input int rd);
        if (mValid && mRw && !mLdm && mDest == rs) return mAlu;
        if (bus.wb_regWrite && int'(bus.wb_writeAddress) == rs) return int'(bus.wb_data);
        return rd;
    endfunction

    // One clock: predict from current inputs and model, advance, compare.
    task automatic step(input string tag);
        int a, b, bsel, r, co;
        a    = pick(int'(bus.rs1), int'(bus.readData1));
        b    = pick(int'(bus.rs2), int'(bus.readData2));
        bsel = bus.AluInputBSel ? int'(bus.const_disp) : b;
        refAlu(int'(bus.ALUfunction), a, bsel, int'(bus.shiftCount), int'(mC), r, co);
        @(posedge clk);
        #1;
        if (rst) begin
            {mC, mZ, mValid, mRw, mMw, mLdm, mWd} = '0;
            mAlu = 0; mStore = 0; mDest = 0; mKnown = 1;
        end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            {mValid, mRw, mMw, mLdm} = '0;
            mKnown = 0;
        end else if (!bus.stall) begin
            mAlu = r; mStore = b; mDest = int'(bus.dest);
            mRw = bus.regWrite_in; mMw = bus.DMMemWrite_in; mLdm = bus.LDM_in;
            mWd = bus.wdSel_in; mValid = 1; mKnown = 1;
            if (bus.Cenb) mC = co[0];
            if (bus.Zenb) mZ = (r == 0);
        end
        chk({tag, ".C"}, 8'(bus.C), 8'(mC));
        chk({tag, ".Z"}, 8'(bus.Z), 8'(mZ));
        chk({tag, ".valid"}, 8'(bus.valid_out), 8'(mValid));
        chk({tag, ".regWrite"}, 8'(bus.regWrite_out), 8'(mRw));
        chk({tag, ".memWrite"}, 8'(bus.DMMemWrite_out), 8'(mMw));
        chk({tag, ".ldm"}, 8'(bus.LDM_out), 8'(mLdm));
        if (mKnown) begin
            chk({tag, ".alu"}, bus.aluResult, 8'(mAlu));
            chk({tag, ".store"}, bus.storeData, 8'(mStore));
            chk({tag, ".dest"}, 8'(bus.dest_out), 8'(mDest));
            chk({tag, ".wdSel"}, 8'(bus.wdSel_out), 8'(mWd));
        end
    endtask

    task automatic setop(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, input logic [2:0] n);
        bus.ALUfunction = f; bus.readData1 = a; bus.readData2 = b; bus.shiftCount = n;
        bus.in_valid = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.Cenb = 1'b1; bus.Zenb = 1'b1; bus.AluInputBSel = 1'b0; bus.const_disp = 8'h00;
        bus.rs1 = 3'd1; bus.rs2 = 3'd1; bus.dest = 3'd5;
        bus.regWrite_in = 1'b0; bus.DMMemWrite_in = 1'b0; bus.LDM_in = 1'b0; bus.wdSel_in = 1'b0;
        bus.wb_regWrite = 1'b0; bus.wb_writeAddress = 3'd0; bus.wb_data = 8'h00;
    endtask

    initial begin
        setop(4'h0, 8'h00, 8'h00, 3'd0);
        {mC, mZ, mValid, mRw, mMw, mLdm, mWd} = '0;
        mAlu = 0; mStore = 0; mDest = 0; mKnown = 1;

        rst = 1'b1; step("reset");
        chk("reset.alu0", bus.aluResult, 8'h00);
        rst = 1'b0;

        setop(4'h0, 8'hF0, 8'h20, 3'd0); step("add");
        chk("add.res", bus.aluResult, 8'h10); chk("add.c", 8'(bus.C), 8'h01);
        setop(4'h1, 8'h01, 8'h01, 3'd0); step("adc");
        chk("adc.res", bus.aluResult, 8'h03);
        setop(4'h2, 8'h05, 8'h05, 3'd0); step("sub0");
        chk("sub0.res", bus.aluResult, 8'h00); chk("sub0.z", 8'(bus.Z), 8'h01); chk("sub0.c", 8'(bus.C), 8'h00);
        setop(4'h2, 8'h03, 8'h05, 3'd0); step("subb");
        chk("subb.res", bus.aluResult, 8'hFE); chk("subb.c", 8'(bus.C), 8'h01);
        setop(4'h9, 8'h81, 8'h00, 3'd1); step("shr");
        chk("shr.res", bus.aluResult, 8'h40); chk("shr.c", 8'(bus.C), 8'h01);
        setop(4'h8, 8'h5A, 8'h00, 3'd0); step("shl0");
        chk("shl0.res", bus.aluResult, 8'h5A); chk("shl0.c", 8'(bus.C), 8'h01);

        setop(4'h0, 8'h30, 8'h03, 3'd0); bus.regWrite_in = 1'b1; bus.dest = 3'd2; step("prod");
        setop(4'hD, 8'h00, 8'h00, 3'd0); bus.rs1 = 3'd2;
        bus.wb_regWrite = 1'b1; bus.wb_writeAddress = 3'd2; bus.wb_data = 8'h77; step("fwdEx");
        chk("fwdEx.res", bus.aluResult, 8'h33);
        setop(4'h0, 8'h10, 8'h00, 3'd0); bus.regWrite_in = 1'b1; bus.LDM_in = 1'b1; bus.dest = 3'd2; step("ldm");
        setop(4'hD, 8'h00, 8'h00, 3'd0); bus.rs1 = 3'd2;
        bus.wb_regWrite = 1'b1; bus.wb_writeAddress = 3'd2; bus.wb_data = 8'h77; step("fwdWb");
        chk("fwdWb.res", bus.aluResult, 8'h77);
        setop(4'hD, 8'h55, 8'h00, 3'd0); bus.rs1 = 3'd2; step("noFwd");
        chk("noFwd.res", bus.aluResult, 8'h55);

        setop(4'h0, 8'h05, 8'h99, 3'd0); bus.AluInputBSel = 1'b1; bus.const_disp = 8'h0A; bus.rs2 = 3'd7; step("imm");
        chk("imm.res", bus.aluResult, 8'h0F); chk("imm.store", bus.storeData, 8'h99);

        setop(4'h0, 8'hF0, 8'h10, 3'd0); bus.regWrite_in = 1'b1; bus.flush = 1'b1; step("flush");
        chk("flush.c", 8'(bus.C), 8'h00); chk("flush.z", 8'(bus.Z), 8'h00);
        chk("flush.valid", 8'(bus.valid_out), 8'h00); chk("flush.rw", 8'(bus.regWrite_out), 8'h00);

        setop(4'h0, 8'h11, 8'h22, 3'd0); bus.regWrite_in = 1'b1; bus.dest = 3'd4; step("preStall");
        for (int i = 0; i < 3; i++) begin
            setop(4'h0, 8'hFF, 8'hFF, 3'd0); bus.stall = 1'b1; step("stall");
            chk("stall.res", bus.aluResult, 8'h33); chk("stall.valid", 8'(bus.valid_out), 8'h01);
        end

        setop(4'h0, 8'hF0, 8'h20, 3'd0); bus.regWrite_in = 1'b1; rst = 1'b1; step("midRst");
        chk("midRst.res", bus.aluResult, 8'h00); chk("midRst.rw", 8'(bus.regWrite_out), 8'h00);
        rst = 1'b0; step("resume");
        chk("resume.res", bus.aluResult, 8'h10); chk("resume.c", 8'(bus.C), 8'h01);

        for (int i = 0; i < 400; i++) begin
            setop(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 3'($urandom));
            bus.rs1 = 3'($urandom); bus.rs2 = 3'($urandom); bus.dest = 3'($urandom);
            bus.AluInputBSel = 1'($urandom); bus.const_disp = 8'($urandom);
            bus.Cenb = 1'($urandom); bus.Zenb = 1'($urandom);
            bus.regWrite_in = 1'($urandom); bus.DMMemWrite_in = 1'($urandom);
            bus.LDM_in = ($urandom_range(0, 3) == 0); bus.wdSel_in = 1'($urandom);
            bus.wb_regWrite = 1'($urandom); bus.wb_writeAddress = 3'($urandom); bus.wb_data = 8'($urandom);
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.in_valid = bus.stall ? 1'b1 : ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 40) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
